// File: rtl/aib_axi_deskew_pkg.sv
// Shared types and helpers for the multi-channel AIB receive deskew block.
package aib_axi_deskew_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEEK    = 2'd1,
    ALIGNED = 2'd2,
    ERROR   = 2'd3
  } deskew_state_t;

  localparam int DEF_MARKER_BIT = 79;
  localparam int DEF_TIMEOUT    = 255;

  // Pointer width carries one extra wrap bit to tell full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/aib_axi_deskew_fifo.sv
// Single-clock per-channel FIFO with synchronous flush and a combinational head read.
module aib_axi_deskew_fifo
  import aib_axi_deskew_pkg::*;
#(
  parameter int DWIDTH = 80,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DWIDTH-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [DWIDTH-1:0] head
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/aib_axi_ch_deskew.sv
// Multi-channel AIB receive deskew: buffers each channel, locks all onto a common
// alignment marker, then releases lane-aligned wide words to the AXI-MM core.
module aib_axi_ch_deskew
  import aib_axi_deskew_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DWIDTH     = 80,
  parameter int FIFO_DEPTH = 8,
  parameter int MARKER_BIT = DEF_MARKER_BIT,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int SKEW_W     = 4
) (
  input  logic                     clk_wr,
  input  logic                     rst_wr,
  input  logic                     align_en,
  input  logic                     rx_online,
  input  logic [NUM_CH*DWIDTH-1:0] rx_data,
  input  logic [NUM_CH-1:0]        rx_valid,
  output logic [NUM_CH*DWIDTH-1:0] out_data,
  output logic                     out_valid,
  output logic                     align_done,
  output logic                     align_err,
  output logic [SKEW_W-1:0]        skew_cycles
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(TIMEOUT);
  localparam logic [SKEW_W-1:0] SKEW_MAX = '1;

  deskew_state_t state_q, state_d;

  logic [NUM_CH-1:0]        lock_q, lock_d;
  logic [NUM_CH-1:0]        push, pop, full, empty, marker_head, lock_set;
  logic [NUM_CH*DWIDTH-1:0] heads;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic [SKEW_W-1:0]        skew_cnt_q, skew_cnt_d;
  logic [SKEW_W-1:0]        skew_cycles_q, skew_cycles_d;
  logic [NUM_CH*DWIDTH-1:0] out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     wr_en, flush, overflow, all_lock, aligned_pop;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    aib_axi_deskew_fifo #(
      .DWIDTH (DWIDTH),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk_wr),
      .rst   (rst_wr),
      .flush (flush),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (rx_data[i*DWIDTH +: DWIDTH]),
      .full  (full[i]),
      .empty (empty[i]),
      .head  (heads[i*DWIDTH +: DWIDTH])
    );
    assign marker_head[i] = !empty[i] && heads[i*DWIDTH + MARKER_BIT];
  end

  // SEEK drains non-marker heads until each channel sits on its marker;
  // ALIGNED pops every channel together once all have a word.
  always_comb begin
    wr_en       = (state_q == SEEK) || (state_q == ALIGNED);
    aligned_pop = (state_q == ALIGNED) && (&(~empty));
    lock_set    = '0;
    pop         = '0;
    if (state_q == SEEK) begin
      lock_set = marker_head & ~lock_q;
      pop      = ~lock_q & ~marker_head & ~empty;
    end else if (aligned_pop) begin
      pop = '1;
    end
    push     = wr_en ? rx_valid : '0;
    overflow = wr_en && (|(rx_valid & full & ~pop));
    all_lock = &(lock_q | lock_set);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (align_en) state_d = SEEK;
      SEEK: begin
        if (!align_en)             state_d = IDLE;
        else if (overflow)         state_d = ERROR;
        else if (all_lock)         state_d = ALIGNED;
        else if (tmo_q == TMO_MAX) state_d = ERROR;
      end
      ALIGNED: begin
        if (!align_en)     state_d = IDLE;
        else if (overflow) state_d = ERROR;
      end
      ERROR:   if (!align_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!rx_online) state_d = IDLE;
  end

  assign flush = (state_q == IDLE) || (state_q == ERROR) ||
                 (state_d == IDLE) || (state_d == ERROR);

  // Lock, timeout and skew tracking only live in SEEK, so entering SEEK starts them at zero.
  always_comb begin
    lock_d        = '0;
    tmo_d         = '0;
    skew_cnt_d    = '0;
    skew_cycles_d = skew_cycles_q;
    if (state_q == SEEK) begin
      lock_d     = lock_q | lock_set;
      tmo_d      = (tmo_q != TMO_MAX) ? tmo_q + TMO_W'(1) : tmo_q;
      skew_cnt_d = skew_cnt_q;
      if ((|lock_q) && (skew_cnt_q != SKEW_MAX)) skew_cnt_d = skew_cnt_q + SKEW_W'(1);
      if (all_lock && (state_d == ALIGNED)) skew_cycles_d = skew_cnt_d;
    end
  end

  always_comb begin
    out_valid_d = aligned_pop && (state_d == ALIGNED);
    out_data_d  = out_valid_d ? heads : out_data_q;
  end

  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      state_q       <= IDLE;
      lock_q        <= '0;
      tmo_q         <= '0;
      skew_cnt_q    <= '0;
      skew_cycles_q <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      lock_q        <= lock_d;
      tmo_q         <= tmo_d;
      skew_cnt_q    <= skew_cnt_d;
      skew_cycles_q <= skew_cycles_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign align_done  = (state_q == ALIGNED);
  assign align_err   = (state_q == ERROR);
  assign skew_cycles = skew_cycles_q;

endmodule
